// File: rtl/elapsed_time_tracker_if.sv
// Control and display bundle between the game FSM / 100 ms timer and the
// elapsed-time tracker; the tracker owns the slave side.
interface elapsed_time_tracker_if;
    logic       tick_100ms;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] tenths;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       overflow;
    logic       second_pulse;
    logic       led_blink;

    modport master (
        output tick_100ms, start, stop, clear,
        input  tenths, sec_ones, sec_tens, min_ones, min_tens,
        input  running, overflow, second_pulse, led_blink
    );

    modport slave (
        input  tick_100ms, start, stop, clear,
        output tenths, sec_ones, sec_tens, min_ones, min_tens,
        output running, overflow, second_pulse, led_blink
    );
endinterface

// File: rtl/elapsed_time_tracker.sv
// Accumulates play time in BCD (MM:SS.t) from a 100 ms tick, with run/pause/clear
// control, saturation at MAX_MINUTES:59.9, a per-second pulse and a status blink.
module elapsed_time_tracker #(
    parameter int unsigned MAX_MINUTES = 32'd59,
    parameter int unsigned BLINK_TICKS = 32'd5
) (
    input  logic                   clk,
    input  logic                   rst,
    elapsed_time_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SAT   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MT     = 4'(MAX_MINUTES / 32'd10);
    localparam logic [3:0] MAX_MO     = 4'(MAX_MINUTES % 32'd10);
    localparam logic [3:0] BLINK_LAST = 4'(BLINK_TICKS - 32'd1);

    state_t     state_q, state_d;
    logic [3:0] tenths_q, tenths_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [2:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       overflow_q, overflow_d;
    logic       pulse_q, pulse_d;
    logic [3:0] blink_cnt_q, blink_cnt_d;
    logic       phase_q, phase_d;
    logic       led_q, led_d;
    logic       running_q, running_d;
    logic       at_max_s;

    // Next-state, digit arithmetic and blink control.
    always_comb begin
        state_d     = state_q;
        tenths_d    = tenths_q;
        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        min_ones_d  = min_ones_q;
        min_tens_d  = min_tens_q;
        overflow_d  = overflow_q;
        pulse_d     = 1'b0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        at_max_s    = (min_tens_q == MAX_MT) && (min_ones_q == MAX_MO) &&
                      (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9) && (tenths_q == 4'd9);

        if (bus.clear) begin
            state_d     = ST_IDLE;
            tenths_d    = 4'd0;
            sec_ones_d  = 4'd0;
            sec_tens_d  = 3'd0;
            min_ones_d  = 4'd0;
            min_tens_d  = 4'd0;
            overflow_d  = 1'b0;
            blink_cnt_d = 4'd0;
            phase_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (!bus.stop && bus.start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (bus.tick_100ms) begin
                        if (blink_cnt_q >= BLINK_LAST) begin
                            blink_cnt_d = 4'd0;
                            phase_d     = ~phase_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 4'd1;
                        end
                        if (at_max_s) begin
                            state_d    = ST_SAT;
                            overflow_d = 1'b1;
                        end else if (tenths_q != 4'd9) begin
                            tenths_d = tenths_q + 4'd1;
                        end else begin
                            // Ripple the BCD carry up through the digit chain.
                            tenths_d = 4'd0;
                            pulse_d  = 1'b1;
                            if (sec_ones_q != 4'd9) begin
                                sec_ones_d = sec_ones_q + 4'd1;
                            end else begin
                                sec_ones_d = 4'd0;
                                if (sec_tens_q != 3'd5) begin
                                    sec_tens_d = sec_tens_q + 3'd1;
                                end else begin
                                    sec_tens_d = 3'd0;
                                    if (min_ones_q != 4'd9) begin
                                        min_ones_d = min_ones_q + 4'd1;
                                    end else begin
                                        min_ones_d = 4'd0;
                                        min_tens_d = min_tens_q + 4'd1;
                                    end
                                end
                            end
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_SAT: begin
                    if (bus.tick_100ms) begin
                        phase_d = ~phase_q;
                    end else begin
                        phase_d = phase_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        case (state_d)
            ST_IDLE:         led_d = 1'b0;
            ST_PAUSE:        led_d = 1'b1;
            ST_RUN, ST_SAT:  led_d = phase_d;
            default:         led_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tenths_q    <= 4'd0;
            sec_ones_q  <= 4'd0;
            sec_tens_q  <= 3'd0;
            min_ones_q  <= 4'd0;
            min_tens_q  <= 4'd0;
            overflow_q  <= 1'b0;
            pulse_q     <= 1'b0;
            blink_cnt_q <= 4'd0;
            phase_q     <= 1'b0;
            led_q       <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tenths_q    <= tenths_d;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            min_tens_q  <= min_tens_d;
            overflow_q  <= overflow_d;
            pulse_q     <= pulse_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            running_q   <= running_d;
        end
    end

    assign bus.tenths       = tenths_q;
    assign bus.sec_ones     = sec_ones_q;
    assign bus.sec_tens     = sec_tens_q;
    assign bus.min_ones     = min_ones_q;
    assign bus.min_tens     = min_tens_q;
    assign bus.running      = running_q;
    assign bus.overflow     = overflow_q;
    assign bus.second_pulse = pulse_q;
    assign bus.led_blink    = led_q;

endmodule
